fft_result_drain: RTL and testbench

FFT_RESULT_DRAIN -- requirements
Module: fft_result_drain

---
 rtl/fft_pkg.sv | 16 +
 rtl/fft_sync_fifo.sv | 69 ++++++
 rtl/fft_result_drain.sv | 117 +++++++++++
 tb/tb_fft_result_drain.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared constants and state encoding for the FFT result drain.
// Imported by the skid FIFO and the drain top level.
package fft_pkg;

  localparam int FFT_W     = 64;
  localparam int FFT_N     = 1024;
  localparam int FFT_DEPTH = 8;
  localparam int FFT_AFULL = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_FLUSH = 2'd2
  } drain_state_e;

endpackage

// File: rtl/fft_sync_fifo.sv
// Single-clock skid FIFO for FFT result samples.
// Registered full/empty/free count and almost-full backpressure flag.
module fft_sync_fifo
  import fft_pkg::*;
#(
  parameter int DEPTH = FFT_DEPTH
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             push_i,
  input  logic [FFT_W-1:0] wdata_i,
  input  logic             pop_i,
  output logic             wr_ok_o,
  output logic [FFT_W-1:0] rdata_o,
  output logic             empty_o,
  output logic             afull_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FREE_MAX = (AW+1)'(DEPTH);
  localparam logic [AW:0] AF_LIM   = (AW+1)'(FFT_AFULL);

  logic [FFT_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wp_q, rp_q;
  logic [AW:0]      free_q, free_d;
  logic             full_q, empty_q, afull_q;
  logic             wr_en, rd_en;

  assign rd_en = pop_i && !empty_q;
  // A full FIFO still takes a write when the head leaves this cycle.
  assign wr_en = push_i && (!full_q || rd_en);

  always_comb begin
    free_d = free_q;
    unique case ({wr_en, rd_en})
      2'b10:   free_d = free_q - (AW+1)'(1);
      2'b01:   free_d = free_q + (AW+1)'(1);
      default: free_d = free_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wp_q] <= wdata_i;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wp_q    <= '0;
      rp_q    <= '0;
      free_q  <= FREE_MAX;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      afull_q <= 1'b0;
    end else begin
      if (wr_en) wp_q <= wp_q + 1'b1;
      if (rd_en) rp_q <= rp_q + 1'b1;
      free_q  <= free_d;
      full_q  <= (free_d == '0);
      empty_q <= (free_d == FREE_MAX);
      afull_q <= (free_d <= AF_LIM);
    end
  end

  assign wr_ok_o = wr_en;
  assign rdata_o = mem_q[rp_q];
  assign empty_o = empty_q;
  assign afull_o = afull_q;

endmodule

// File: rtl/fft_result_drain.sv
// Drains FFT result samples through a skid FIFO to a valid/ready
// downlink, tracking frame length and flagging length/overflow errors.
module fft_result_drain
  import fft_pkg::*;
#(
  parameter int N     = FFT_N,
  parameter int DEPTH = FFT_DEPTH
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        fft_ready_i,
  input  logic        fft_done_i,
  input  logic [31:0] x0_re_i,
  input  logic [31:0] x0_im_i,
  output logic        dl_busy_o,
  output logic        m_valid_o,
  input  logic        m_ready_i,
  output logic [63:0] m_data_o,
  output logic        m_last_o,
  output logic        frame_done_o,
  output logic        len_err_o,
  output logic        ovf_err_o
);

  localparam int CW = $clog2(N) + 1;
  localparam logic [CW-1:0] NC = CW'(N);
  localparam logic [CW-1:0] NL = CW'(N - 1);

  drain_state_e     state_q;
  logic [CW-1:0]    wr_cnt_q, wr_cnt_d, rd_cnt_q;
  logic             done_q, len_q, ovf_q;

  logic             empty, afull, wr_ok;
  logic [FFT_W-1:0] rdata;
  logic             hs, last_hs, flush_exit;
  logic             frame_ok, push, ovf, excess;

  assign hs         = !empty && m_ready_i;
  assign last_hs    = hs && (rd_cnt_q == NL);
  assign flush_exit = (state_q == ST_FLUSH) && (last_hs || empty);

  // In FLUSH only the exit cycle may open the next frame.
  always_comb begin
    frame_ok = 1'b0;
    unique case (state_q)
      ST_IDLE:  frame_ok = 1'b1;
      ST_DRAIN: frame_ok = (wr_cnt_q != NC);
      ST_FLUSH: frame_ok = flush_exit;
      default:  frame_ok = 1'b0;
    endcase
  end

  assign push     = fft_ready_i && frame_ok;
  assign ovf      = push && !wr_ok;
  assign excess   = fft_ready_i && !frame_ok && (wr_cnt_q == NC);
  assign wr_cnt_d = wr_cnt_q + CW'(wr_ok);

  fft_sync_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rstn   (rstn),
    .push_i (push),
    .wdata_i({x0_im_i, x0_re_i}),
    .pop_i  (m_ready_i),
    .wr_ok_o(wr_ok),
    .rdata_o(rdata),
    .empty_o(empty),
    .afull_o(afull)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= ST_IDLE;
      wr_cnt_q <= '0;
      rd_cnt_q <= '0;
      done_q   <= 1'b0;
      len_q    <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      done_q <= last_hs;
      if (ovf)    ovf_q <= 1'b1;
      if (excess) len_q <= 1'b1;
      wr_cnt_q <= wr_cnt_d;
      if (hs) rd_cnt_q <= rd_cnt_q + 1'b1;
      unique case (state_q)
        ST_IDLE: begin
          if (fft_done_i) len_q   <= 1'b1;
          if (wr_ok)      state_q <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (fft_done_i) begin
            state_q <= ST_FLUSH;
            if (wr_cnt_d != NC) len_q <= 1'b1;
          end
        end
        ST_FLUSH: begin
          if (flush_exit) begin
            rd_cnt_q <= '0;
            wr_cnt_q <= CW'(wr_ok);
            state_q  <= wr_ok ? ST_DRAIN : ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign dl_busy_o    = afull;
  assign m_valid_o    = !empty;
  assign m_data_o     = empty ? '0 : rdata;
  assign m_last_o     = !empty && (rd_cnt_q == NL);
  assign frame_done_o = done_q;
  assign len_err_o    = len_q;
  assign ovf_err_o    = ovf_q;

endmodule

// File: tb/tb_fft_result_drain.sv
// Scoreboard bench for fft_result_drain (N=16, DEPTH=8).
// Transaction-level model predicts beats; a monitor checks them.
module tb_fft_result_drain;

  localparam int N = 16;
  localparam int D = 8;

  logic        clk, rstn;
  logic        fft_ready_i, fft_done_i;
  logic [31:0] x0_re_i, x0_im_i;
  logic        dl_busy_o, m_valid_o, m_ready_i;
  logic [63:0] m_data_o;
  logic        m_last_o, frame_done_o, len_err_o, ovf_err_o;

  fft_result_drain #(.N(N), .DEPTH(D)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .fft_ready_i (fft_ready_i),
    .fft_done_i  (fft_done_i),
    .x0_re_i     (x0_re_i),
    .x0_im_i     (x0_im_i),
    .dl_busy_o   (dl_busy_o),
    .m_valid_o   (m_valid_o),
    .m_ready_i   (m_ready_i),
    .m_data_o    (m_data_o),
    .m_last_o    (m_last_o),
    .frame_done_o(frame_done_o),
    .len_err_o   (len_err_o),
    .ovf_err_o   (ovf_err_o)
  );

  typedef struct {
    logic [63:0] d;
    bit          last;
  } beat_t;

  beat_t exq[$];
  int    n_cmp, n_bad;
  int    beats, lasts, fd_cnt;
  int    rdy_pct;

  // reference model state
  int occ, fcnt, dcnt;
  bit done_seen;
  bit e_busy, e_fd, e_len, e_ovf;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #900000;
    $display("FAIL global_timeout");
    $fatal(1, "bench timeout");
  end

  initial begin
    m_ready_i = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      m_ready_i = ($urandom_range(99) < rdy_pct);
    end
  end

  // Model: FIFO as an occupancy count, frames as sample/beat counts.
  initial begin
    bit pop, plast, ex, ok, acc;
    int idx;
    forever begin
      @(posedge clk or negedge rstn);
      if (!rstn) begin
        occ = 0; fcnt = 0; dcnt = 0; done_seen = 0;
        e_busy = 0; e_fd = 0; e_len = 0; e_ovf = 0;
        exq.delete();
      end else begin
        pop   = (occ > 0) && m_ready_i;
        plast = pop && (dcnt == N - 1);
        ex    = done_seen && (occ == 0 || plast);
        ok    = done_seen ? ex : (fcnt < N);
        acc   = 0;
        if (fft_ready_i && !ok && fcnt == N) e_len = 1;
        if (fft_ready_i && ok) begin
          if (occ < D || pop) begin
            acc = 1;
            idx = ex ? 0 : fcnt;
            exq.push_back('{d: {x0_im_i, x0_re_i}, last: (idx == N - 1)});
          end else begin
            e_ovf = 1;
          end
        end
        if (fft_done_i && !done_seen) begin
          if (fcnt == 0) e_len = 1;
          else begin
            done_seen = 1;
            if (fcnt + int'(acc) != N) e_len = 1;
          end
        end
        e_fd = plast;
        occ  = occ + int'(acc) - int'(pop);
        if (pop) dcnt++;
        if (ex) begin
          fcnt = int'(acc); dcnt = 0; done_seen = 0;
        end else begin
          fcnt = fcnt + int'(acc);
        end
        e_busy = (D - occ) <= 2;
      end
    end
  end

  // Monitor: compare DUT against model and scoreboard away from the edge.
  initial begin
    bit          pv, pr, pl;
    logic [63:0] pd;
    beat_t       b;
    pv = 0; pr = 0; pl = 0; pd = '0;
    forever begin
      @(negedge clk);
      chk("valid", m_valid_o, occ > 0);
      chk("busy", dl_busy_o, e_busy);
      chk("frame_done", frame_done_o, e_fd);
      chk("len_err", len_err_o, e_len);
      chk("ovf_err", ovf_err_o, e_ovf);
      if (frame_done_o) fd_cnt++;
      if (pv && !pr && m_valid_o) begin
        chk("hold_data", m_data_o, pd);
        chk("hold_last", m_last_o, pl);
      end
      if (m_valid_o && m_ready_i) begin
        beats++;
        if (m_last_o) lasts++;
        if (exq.size() == 0) begin
          chk("unexpected_beat", 1, 0);
        end else begin
          b = exq.pop_front();
          chk("beat_data", m_data_o, b.d);
          chk("beat_last", m_last_o, b.last);
        end
      end
      pv = m_valid_o; pr = m_ready_i; pd = m_data_o; pl = m_last_o;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input int k, input bit honor,
                            input int gap, input bit done_last);
    int sent, cyc;
    bit bprev;
    sent = 0; cyc = 0; bprev = 0;
    while (sent < k && cyc < 3000) begin
      if ((honor && bprev) || $urandom_range(99) < gap) begin
        fft_ready_i = 0;
        fft_done_i  = 0;
      end else begin
        fft_ready_i = 1;
        x0_re_i     = $urandom;
        x0_im_i     = $urandom;
        fft_done_i  = done_last && (sent == k - 1);
        sent++;
      end
      bprev = dl_busy_o;
      tick();
      cyc++;
    end
    fft_ready_i = 0;
    fft_done_i  = 0;
    chk("producer_sent", sent, k);
  endtask

  task automatic pulse_done();
    fft_done_i = 1;
    tick();
    fft_done_i = 0;
  endtask

  task automatic wait_drain();
    int cyc;
    cyc = 0;
    while (!(occ == 0 && fcnt == 0 && !done_seen) && cyc < 2000) begin
      tick();
      cyc++;
    end
    chk("drain_done", cyc < 2000, 1);
    repeat (3) tick();
  endtask

  initial begin
    int b0, l0, f0, k;
    int lens[6];
    lens = '{16, 16, 16, 12, 18, 5};
    n_cmp = 0; n_bad = 0; beats = 0; lasts = 0; fd_cnt = 0;
    rdy_pct = 100;
    rstn = 0; fft_ready_i = 0; fft_done_i = 0; x0_re_i = 0; x0_im_i = 0;
    repeat (3) tick();
    chk("rst_valid", m_valid_o, 0);
    chk("rst_busy", dl_busy_o, 0);
    chk("rst_data", m_data_o, 0);
    chk("rst_last", m_last_o, 0);
    chk("rst_errs", {len_err_o, ovf_err_o, frame_done_o}, 0);
    rstn = 1;
    repeat (2) tick();

    // continuous frame, sink always ready
    b0 = beats; l0 = lasts; f0 = fd_cnt;
    send_frame(N, 0, 0, 0);
    pulse_done();
    wait_drain();
    chk("f1_beats", beats - b0, N);
    chk("f1_lasts", lasts - l0, 1);
    chk("f1_done", fd_cnt - f0, 1);
    chk("f1_errs", {len_err_o, ovf_err_o}, 0);

    // stalled sink, producer honours busy
    b0 = beats; rdy_pct = 0;
    fork
      send_frame(N, 1, 0, 0);
      begin repeat (14) tick(); rdy_pct = 100; end
    join
    pulse_done();
    wait_drain();
    chk("f2_beats", beats - b0, N);
    chk("f2_ovf", ovf_err_o, 0);

    // back-to-back frames: next sample lands on the FLUSH exit cycle
    b0 = beats; f0 = fd_cnt;
    send_frame(N, 0, 0, 1);
    send_frame(N, 0, 0, 1);
    wait_drain();
    chk("b2b_beats", beats - b0, 2 * N);
    chk("b2b_done", fd_cnt - f0, 2);
    chk("b2b_len", len_err_o, 0);

    // short frame
    b0 = beats; l0 = lasts; f0 = fd_cnt;
    send_frame(12, 0, 0, 0);
    pulse_done();
    wait_drain();
    chk("short_beats", beats - b0, 12);
    chk("short_lasts", lasts - l0, 0);
    chk("short_done", fd_cnt - f0, 0);
    chk("short_len", len_err_o, 1);

    // producer ignores busy with a stalled sink
    b0 = beats; rdy_pct = 0;
    send_frame(10, 0, 0, 0);
    pulse_done();
    chk("ovf_flag", ovf_err_o, 1);
    rdy_pct = 100;
    wait_drain();
    chk("ovf_beats", beats - b0, D);

    // reset mid-frame with five entries queued
    rdy_pct = 0;
    send_frame(5, 0, 0, 0);
    rstn = 0;
    #1;
    chk("mid_rst_valid", m_valid_o, 0);
    chk("mid_rst_busy", dl_busy_o, 0);
    chk("mid_rst_errs", {len_err_o, ovf_err_o}, 0);
    tick();
    rstn = 1;
    rdy_pct = 100;
    tick();
    b0 = beats; f0 = fd_cnt;
    send_frame(N, 0, 0, 0);
    pulse_done();
    wait_drain();
    chk("post_rst_beats", beats - b0, N);
    chk("post_rst_done", fd_cnt - f0, 1);

    // randomized frames
    for (int i = 0; i < 20; i++) begin
      k = lens[$urandom_range(5)];
      rdy_pct = $urandom_range(100, 20);
      send_frame(k, 1'($urandom_range(1)), $urandom_range(40),
                 1'($urandom_range(1)));
      if (done_seen == 0 && fcnt != 0) pulse_done();
      rdy_pct = 100;
      wait_drain();
    end

    chk("sb_empty", exq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
